// File: rtl/trng_pkg.sv
// Shared defaults and helpers for the TRNG output consumers.
package trng_pkg;

    localparam int unsigned DEF_WORD_W     = 32;
    localparam int unsigned DEF_DROP_W     = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    // Next value of a w-bit saturating up-counter (w <= 32); holds at all-ones.
    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned w);
        int unsigned max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/trng_sync_fifo.sv
// Parametric synchronous FIFO; read data comes straight from the storage flops.
module trng_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // A pop frees the head slot first, so a push into a full FIFO is taken when a pop coincides.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr[AW-1:0]];

    // Pointer advance and storage write; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= din;
                wptr              <= wptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/trng_out_packer.sv
// Packs the generator's serial keystream LSB-first into words, buffers them,
// and flags dropped words and back-to-back identical words.
module trng_out_packer
    import trng_pkg::*;
#(
    parameter int unsigned WORD_W     = DEF_WORD_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned DROP_W     = DEF_DROP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              stuck,
    input  logic              clear
);

    localparam int unsigned BW = $clog2(WORD_W);

    logic [BW-1:0]     bcnt;
    logic [WORD_W-1:0] partial;
    logic [WORD_W-1:0] cur_word;
    logic [WORD_W-1:0] prev_word;
    logic              have_prev;
    logic              word_done;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              drop_evt;
    logic              stuck_evt;

    assign word_done  = bit_valid && (bcnt == BW'(WORD_W - 1));
    assign word_valid = !fifo_empty;
    assign pop        = !fifo_empty && word_ready;
    assign drop_evt   = word_done && fifo_full && !pop;
    assign stuck_evt  = word_done && have_prev && (cur_word == prev_word);

    // Completed word: stored low bits with the live bit_in as the MSB.
    always_comb begin
        cur_word             = partial;
        cur_word[WORD_W-1]   = bit_in;
    end

    // Bit position counter and partial word; idle cycles hold both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt    <= '0;
            partial <= '0;
        end else if (bit_valid) begin
            partial[bcnt] <= bit_in;
            bcnt          <= word_done ? '0 : bcnt + BW'(1);
        end
    end

    // Remember the last completed word (pushed or dropped) for the stuck comparison.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_word <= '0;
            have_prev <= 1'b0;
        end else if (word_done) begin
            prev_word <= cur_word;
            have_prev <= 1'b1;
        end
    end

    // Sticky flags and drop counter; a same-cycle event takes precedence over clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
            stuck    <= 1'b0;
        end else begin
            if (drop_evt) begin
                overflow <= 1'b1;
                drop_cnt <= clear ? DROP_W'(1) : DROP_W'(sat_inc(32'(drop_cnt), DROP_W));
            end else if (clear) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
            if (stuck_evt) begin
                stuck <= 1'b1;
            end else if (clear) begin
                stuck <= 1'b0;
            end
        end
    end

    trng_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (word_done),
        .pop   (pop),
        .din   (cur_word),
        .dout  (word_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
